// File: rtl/pipe_ram_slave_pkg.sv
// Shared types and limits for the pipelined Wishbone RAM responder.
package pipe_ram_slave_pkg;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 4;
  localparam int DW          = 32;

  typedef struct packed {
    logic valid;
    logic bad;
  } resp_t;

  localparam resp_t RESP_NONE = '{valid: 1'b0, bad: 1'b0};

  function automatic logic resp_ack(input resp_t e);
    return e.valid & ~e.bad;
  endfunction

  function automatic logic resp_err(input resp_t e);
    return e.valid & e.bad;
  endfunction

endpackage

// File: rtl/pipe_ram_slave_if.sv
// Pipelined Wishbone bus plus local hold, seen from master and slave.
interface pipe_ram_slave_if
  import pipe_ram_slave_pkg::*;
#(
  parameter int AW = 24
);
  logic          i_wb_cyc;
  logic          i_wb_stb;
  logic          i_wb_we;
  logic [AW-1:0] i_wb_addr;
  logic [DW-1:0] i_wb_data;
  logic          i_hold;
  logic          o_wb_stall;
  logic          o_wb_ack;
  logic          o_wb_err;
  logic [DW-1:0] o_wb_data;

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_hold,
    output o_wb_stall, o_wb_ack, o_wb_err, o_wb_data
  );

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_hold,
    input  o_wb_stall, o_wb_ack, o_wb_err, o_wb_data
  );
endinterface

// File: rtl/pipe_ram_slave_wb_resp_delay.sv
// Fixed-depth shift line of response entries with bus-abort flush and
// an input squash used while the error lock holds the bus.
module wb_resp_delay
  import pipe_ram_slave_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 squash_i,
  input  resp_t                entry_i,
  output resp_t [LATENCY-1:0]  stage_o
);

  resp_t [LATENCY-1:0] stage_q;
  resp_t [LATENCY-1:0] stage_d;

  // Shift next-state; an abort clears every stage at once.
  always_comb begin
    stage_d = stage_q;
    if (flush_i) begin
      for (int k = 0; k < LATENCY; k++) begin
        stage_d[k] = RESP_NONE;
      end
    end else begin
      if (squash_i) begin
        stage_d[0] = RESP_NONE;
      end else begin
        stage_d[0] = entry_i;
      end
      for (int k = 1; k < LATENCY; k++) begin
        stage_d[k] = stage_q[k-1];
      end
    end
  end

  // Stage registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < LATENCY; k++) begin
        stage_q[k] <= RESP_NONE;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign stage_o = stage_q;

endmodule

// File: rtl/pipe_ram_slave.sv
// Pipelined Wishbone responder in front of a 2^LGMEMSZ-word RAM with
// in-order ack/err after a fixed latency, error lock and local hold.
module pipe_ram_slave
  import pipe_ram_slave_pkg::*;
#(
  parameter int AW      = 24,
  parameter int LGMEMSZ = 10,
  parameter int LATENCY = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  pipe_ram_slave_if.slave bus
);

  localparam int LAT   = (LATENCY < LATENCY_MIN) ? LATENCY_MIN :
                         (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;
  localparam int DEPTH = 1 << LGMEMSZ;

  logic               stall_s;
  logic               accept_s;
  logic               bad_s;
  logic               good_acc_s;
  logic               errlock_q;
  logic               errlock_d;
  logic [LGMEMSZ-1:0] idx_s;
  resp_t              entry_s;
  resp_t [LAT-1:0]    stage_s;
  logic [DW-1:0]      mem_q  [DEPTH];
  logic [DW-1:0]      data_q [LAT];
  logic [DW-1:0]      data_d [LAT];

  generate
    if (LGMEMSZ < AW) begin : g_decode
      assign bad_s = |bus.i_wb_addr[AW-1:LGMEMSZ];
    end else begin : g_full
      assign bad_s = 1'b0;
    end
  endgenerate

  assign idx_s      = bus.i_wb_addr[LGMEMSZ-1:0];
  assign stall_s    = bus.i_hold | errlock_q;
  assign accept_s   = bus.i_wb_cyc & bus.i_wb_stb & ~stall_s;
  assign good_acc_s = accept_s & ~bad_s;

  // Response entry for the request accepted this clock.
  always_comb begin
    entry_s       = RESP_NONE;
    entry_s.valid = accept_s;
    entry_s.bad   = bad_s;
  end

  // Error lock: set by a bad accept, released only when the cycle ends.
  always_comb begin
    errlock_d = errlock_q;
    if (!bus.i_wb_cyc) begin
      errlock_d = 1'b0;
    end else if (accept_s && bad_s) begin
      errlock_d = 1'b1;
    end else begin
      errlock_d = errlock_q;
    end
  end

  // Data line: stage 0 is the registered RAM read; later stages only move
  // alongside a good entry, so the output holds between acks.
  always_comb begin
    for (int k = 0; k < LAT; k++) begin
      data_d[k] = data_q[k];
    end
    if (good_acc_s) begin
      data_d[0] = mem_q[idx_s];
    end else begin
      data_d[0] = data_q[0];
    end
    for (int k = 1; k < LAT; k++) begin
      if (bus.i_wb_cyc && resp_ack(stage_s[k-1])) begin
        data_d[k] = data_q[k-1];
      end else begin
        data_d[k] = data_q[k];
      end
    end
  end

  // RAM array write port; contents deliberately survive reset.
  always_ff @(posedge i_clk) begin
    if (good_acc_s && bus.i_wb_we) begin
      mem_q[idx_s] <= bus.i_wb_data;
    end
  end

  // Error lock and data line registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      errlock_q <= 1'b0;
      for (int k = 0; k < LAT; k++) begin
        data_q[k] <= 32'h0000_0000;
      end
    end else begin
      errlock_q <= errlock_d;
      data_q    <= data_d;
    end
  end

  wb_resp_delay #(
    .LATENCY (LAT)
  ) u_resp_delay (
    .clk_i    (i_clk),
    .rst_i    (i_rst),
    .flush_i  (~bus.i_wb_cyc),
    .squash_i (errlock_q),
    .entry_i  (entry_s),
    .stage_o  (stage_s)
  );

  assign bus.o_wb_stall = stall_s;
  assign bus.o_wb_ack   = resp_ack(stage_s[LAT-1]);
  assign bus.o_wb_err   = resp_err(stage_s[LAT-1]);
  assign bus.o_wb_data  = data_q[LAT-1];

endmodule

// File: tb/tb_pipe_ram_slave.sv
// Scoreboard bench: two responders (latency 2 and 4) share one stimulus
// stream; a timed-queue model predicts each ack/err cycle and read data.
module tb_pipe_ram_slave;

  localparam int AW    = 24;
  localparam int LG    = 10;
  localparam int DEPTH = 1 << LG;

  typedef struct {
    int          due;
    logic        err;
    logic        rd;
    logic        known;
    logic [31:0] data;
  } exp_t;

  logic          clk   = 1'b0;
  logic          rst   = 1'b0;
  logic          cyc   = 1'b0;
  logic          stb   = 1'b0;
  logic          we    = 1'b0;
  logic          hold  = 1'b0;
  logic [AW-1:0] addr  = '0;
  logic [31:0]   wdata = 32'h0;

  exp_t        expq [2][$];
  int          lat  [2] = '{2, 4};
  logic [31:0] mem_m [int];
  int          edge_cnt  = 0;
  logic        errlock_m = 1'b0;
  logic        acc_flag  = 1'b0;
  exp_t        m_e;
  logic        m_bad;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  pipe_ram_slave_if #(.AW(AW)) bus2 ();
  pipe_ram_slave_if #(.AW(AW)) bus4 ();

  assign bus2.i_wb_cyc  = cyc;
  assign bus2.i_wb_stb  = stb;
  assign bus2.i_wb_we   = we;
  assign bus2.i_wb_addr = addr;
  assign bus2.i_wb_data = wdata;
  assign bus2.i_hold    = hold;
  assign bus4.i_wb_cyc  = cyc;
  assign bus4.i_wb_stb  = stb;
  assign bus4.i_wb_we   = we;
  assign bus4.i_wb_addr = addr;
  assign bus4.i_wb_data = wdata;
  assign bus4.i_hold    = hold;

  pipe_ram_slave #(.AW(AW), .LGMEMSZ(LG), .LATENCY(2)) dut2 (
    .i_clk (clk), .i_rst (rst), .bus (bus2)
  );
  pipe_ram_slave #(.AW(AW), .LGMEMSZ(LG), .LATENCY(4)) dut4 (
    .i_clk (clk), .i_rst (rst), .bus (bus4)
  );

  // Reference model: decides acceptance and schedules responses by edge index.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) expq[d].delete();
      errlock_m = 1'b0;
      acc_flag  = 1'b0;
    end else begin
      edge_cnt++;
      acc_flag = 1'b0;
      if (!cyc) begin
        for (int d = 0; d < 2; d++)
          for (int i = expq[d].size() - 1; i >= 0; i--)
            if (expq[d][i].due >= edge_cnt) expq[d].delete(i);
        errlock_m = 1'b0;
      end else if (stb && !hold && !errlock_m) begin
        acc_flag  = 1'b1;
        m_bad     = (int'(addr) >= DEPTH);
        m_e.err   = m_bad;
        m_e.rd    = !we;
        m_e.known = !m_bad && mem_m.exists(int'(addr));
        m_e.data  = m_e.known ? mem_m[int'(addr)] : 32'h0;
        if (!m_bad && we) mem_m[int'(addr)] = wdata;
        for (int d = 0; d < 2; d++) begin
          m_e.due = edge_cnt + lat[d] - 1;
          expq[d].push_back(m_e);
        end
        if (m_bad) errlock_m = 1'b1;
      end
    end
  end

  task automatic check_dut(input int d, input logic ack, input logic err,
                           input logic [31:0] data, input logic stall);
    logic exp_ack = 1'b0;
    logic exp_err = 1'b0;
    logic have    = 1'b0;
    exp_t e;
    if (rst) begin
      checks++;
      if (ack !== 1'b0 || err !== 1'b0 || data !== 32'h0) begin
        errors++;
        $display("FAIL reset_out[L%0d]: got ack=%b err=%b data=%h want 0 0 0",
                 lat[d], ack, err, data);
      end
    end else begin
      while (expq[d].size() > 0 && expq[d][0].due < edge_cnt) begin
        void'(expq[d].pop_front());
        checks++;
        errors++;
        $display("FAIL stale[L%0d]: response overdue at edge %0d", lat[d], edge_cnt);
      end
      if (expq[d].size() > 0 && expq[d][0].due == edge_cnt) begin
        e       = expq[d].pop_front();
        have    = 1'b1;
        exp_ack = !e.err;
        exp_err = e.err;
      end
      checks++;
      if (ack !== exp_ack || err !== exp_err) begin
        errors++;
        $display("FAIL resp[L%0d] edge %0d: got ack=%b err=%b want ack=%b err=%b",
                 lat[d], edge_cnt, ack, err, exp_ack, exp_err);
      end
      if (have && e.rd && e.known && !e.err) begin
        checks++;
        if (data !== e.data) begin
          errors++;
          $display("FAIL rdata[L%0d] edge %0d: got %h want %h", lat[d], edge_cnt, data, e.data);
        end
      end
    end
    checks++;
    if (stall !== (hold | errlock_m)) begin
      errors++;
      $display("FAIL stall[L%0d] edge %0d: got %b want %b", lat[d], edge_cnt, stall, hold | errlock_m);
    end
  endtask

  // Monitor: compares both responders against the scoreboard mid-cycle.
  always @(negedge clk) begin
    check_dut(0, bus2.o_wb_ack, bus2.o_wb_err, bus2.o_wb_data, bus2.o_wb_stall);
    check_dut(1, bus4.o_wb_ack, bus4.o_wb_err, bus4.o_wb_data, bus4.o_wb_stall);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic w, input logic [AW-1:0] a, input logic [31:0] dat);
    cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = dat;
    for (int n = 0; n < 20; n++) begin
      step();
      if (acc_flag) break;
    end
    checks++;
    if (!acc_flag) begin
      errors++;
      $display("FAIL accept_timeout: addr %h not accepted within 20 cycles", a);
    end
    stb = 1'b0;
  endtask

  task automatic drain_idle();
    stb = 1'b0;
    repeat (6) step();
    cyc = 1'b0;
    repeat (2) step();
  endtask

  initial begin
    #2 rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    step();

    // Single write then read back.
    req(1'b1, 24'h000005, 32'hDEAD_BEEF);
    req(1'b0, 24'h000005, 32'h0);
    drain_idle();

    // Preload 0..7, then back-to-back reads.
    for (int i = 0; i < 8; i++) req(1'b1, 24'(i), 32'h1111_1111 * 32'(i));
    for (int i = 0; i < 8; i++) req(1'b0, 24'(i), 32'h0);
    drain_idle();

    // Out-of-range read inside a burst of three; third stays stalled.
    cyc = 1'b1; stb = 1'b1; we = 1'b0;
    addr = 24'h000001; step();
    addr = 24'h000400; step();
    addr = 24'h000002; repeat (5) step();
    stb = 1'b0; cyc = 1'b0; repeat (2) step();

    // Local hold for three cycles mid-burst.
    req(1'b0, 24'h000000, 32'h0);
    req(1'b0, 24'h000001, 32'h0);
    stb = 1'b1; addr = 24'h000002; hold = 1'b1;
    repeat (3) step();
    hold = 1'b0;
    for (int i = 2; i < 6; i++) req(1'b0, 24'(i), 32'h0);
    drain_idle();

    // Abort one cycle after two reads, then a fresh cycle.
    req(1'b0, 24'h000003, 32'h0);
    req(1'b0, 24'h000004, 32'h0);
    cyc = 1'b0;
    repeat (6) step();
    req(1'b0, 24'h000006, 32'h0);
    drain_idle();

    // Reset with reads in flight; RAM must survive.
    req(1'b1, 24'h000009, 32'hCAFE_F00D);
    req(1'b0, 24'h000000, 32'h0);
    req(1'b0, 24'h000001, 32'h0);
    req(1'b0, 24'h000002, 32'h0);
    rst = 1'b1; cyc = 1'b0; stb = 1'b0;
    #1;
    checks++;
    if (bus2.o_wb_ack !== 1'b0 || bus4.o_wb_ack !== 1'b0 || bus2.o_wb_err !== 1'b0 ||
        bus4.o_wb_err !== 1'b0 || bus2.o_wb_data !== 32'h0 || bus4.o_wb_data !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: got ack=%b/%b data=%h/%h want all 0",
               bus2.o_wb_ack, bus4.o_wb_ack, bus2.o_wb_data, bus4.o_wb_data);
    end
    step();
    rst = 1'b0;
    repeat (6) step();
    req(1'b0, 24'h000009, 32'h0);
    req(1'b0, 24'h000005, 32'h0);
    req(1'b0, 24'h000007, 32'h0);
    drain_idle();

    // Randomised traffic with holds, aborts and bad addresses.
    for (int n = 0; n < 600; n++) begin
      if (!stb || acc_flag) begin
        stb   = ($urandom_range(0, 3) != 0);
        we    = $urandom_range(0, 1) == 1;
        addr  = ($urandom_range(0, 12) == 0) ? 24'(32'h400 + $urandom_range(0, 4095))
                                             : 24'($urandom_range(0, 15));
        wdata = $urandom;
      end
      hold = ($urandom_range(0, 4) == 0);
      cyc  = ($urandom_range(0, 30) != 0);
      if (!cyc) stb = 1'b0;
      step();
    end
    stb = 1'b0; hold = 1'b0; cyc = 1'b1;
    repeat (8) step();
    checks++;
    if (expq[0].size() != 0 || expq[1].size() != 0) begin
      errors++;
      $display("FAIL drain: pending responses got %0d/%0d want 0/0", expq[0].size(), expq[1].size());
    end
    cyc = 1'b0;
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
